usb_sd_xfer_ctrl: RTL and testbench

Next-generation USB-to-SD transfer sequencer. It adds multi-block transfers, packet-error retry, inactivity timeout and sticky error status.

---
 rtl/usb_ctrl_pkg.sv | 44 ++++
 rtl/usb_sd_xfer_ctrl_timeout.sv | 35 +++
 rtl/usb_sd_xfer_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_usb_sd_xfer_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_ctrl_pkg.sv
// ============================================================================
// Module      : usb_ctrl_pkg
// Description : Shared state, PID and packet-status encodings for the
//               USB-to-SD transfer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR_WAIT = 4'd1,
        ST_ADDR_RDY  = 4'd2,
        ST_CMD_WAIT  = 4'd3,
        ST_DATA_WAIT = 4'd4,
        ST_WRITE     = 4'd5,
        ST_READ      = 4'd6,
        ST_HS        = 4'd7,
        ST_ABORT     = 4'd8
    } state_t;

    // What the handshake currently being sent leads to once it completes.
    typedef enum logic [1:0] {
        HS_GOOD = 2'd0,
        HS_NAK  = 2'd1,
        HS_FAIL = 2'd2
    } hs_kind_t;

    localparam logic [3:0] PID_OUT  = 4'b0001;
    localparam logic [3:0] PID_IN   = 4'b1001;

    localparam logic [1:0] PKT_NONE = 2'b00;
    localparam logic [1:0] PKT_GOOD = 2'b01;
    localparam logic [1:0] PKT_BAD  = 2'b10;

    // Codes 10 and 11 both mean a bad packet.
    function automatic logic pkt_is_bad(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/usb_sd_xfer_ctrl_timeout.sv
// ============================================================================
// Module      : timeout_counter
// Description : Idle-cycle counter that flags expiry on its terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timeout_counter #(
    parameter int WIDTH    = 12,
    parameter int TERMINAL = 4095
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign expire = enable && (r_count == WIDTH'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/usb_sd_xfer_ctrl.sv
// ============================================================================
// Module      : usb_sd_xfer_ctrl
// Description : USB-to-SD multi-block transfer sequencer with packet retry,
//               inactivity timeout and sticky abort status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_sd_xfer_ctrl
    import usb_ctrl_pkg::*;
#(
    parameter int BLK_CNT_W      = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 pid_rdy,
    input  logic [3:0]           rx_pid,
    input  logic [1:0]           rx_packet_done,
    input  logic [BLK_CNT_W-1:0] setup_blk_cnt,
    input  logic                 sd_done,
    input  logic                 sd_err,
    input  logic                 tx_done,
    input  logic                 tx_err,
    output logic                 sd_addr_rdy,
    output logic                 sd_write,
    output logic                 sd_read,
    output logic                 tx_transmit,
    output logic                 tx_send_good,
    output logic                 tx_send_bad,
    output logic                 busy,
    output logic                 xfer_err,
    output logic [BLK_CNT_W-1:0] blocks_left
);

    localparam int c_TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);

    state_t                 r_state, w_next;
    hs_kind_t               r_hs_kind, w_hs_kind;
    logic [c_RETRY_W-1:0]   r_retry, w_retry, w_retry_inc;
    logic [BLK_CNT_W-1:0]   r_blocks, w_blocks;
    logic                   r_xfer_err, w_xfer_err;
    logic                   w_to_en, w_to_expire;

    logic r_sd_addr_rdy, r_sd_write, r_sd_read;
    logic r_tx_transmit, r_tx_send_good, r_tx_send_bad, r_busy;

    assign w_to_en = (r_state == ST_ADDR_WAIT) || (r_state == ST_CMD_WAIT) ||
                     (r_state == ST_DATA_WAIT) || (r_state == ST_WRITE)    ||
                     (r_state == ST_READ)      || (r_state == ST_HS);

    timeout_counter #(
        .WIDTH    (c_TO_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (w_next != r_state),
        .enable (w_to_en),
        .expire (w_to_expire)
    );

    assign w_retry_inc = r_retry + c_RETRY_W'(1);

    // Qualifying inputs are checked ahead of the timeout so they win a tie.
    always_comb begin
        w_next     = r_state;
        w_hs_kind  = r_hs_kind;
        w_retry    = r_retry;
        w_blocks   = r_blocks;
        w_xfer_err = r_xfer_err;
        case (r_state)
            ST_IDLE: begin
                w_retry = '0;
                if (pid_rdy && (rx_pid == PID_OUT)) begin
                    w_next     = ST_ADDR_WAIT;
                    w_xfer_err = 1'b0;
                end
            end
            ST_ADDR_WAIT: begin
                if (rx_packet_done == PKT_GOOD) begin
                    w_blocks = (setup_blk_cnt == '0) ? BLK_CNT_W'(1) : setup_blk_cnt;
                    w_next   = ST_ADDR_RDY;
                end else if (pkt_is_bad(rx_packet_done)) begin
                    w_next = ST_IDLE;
                end else if (w_to_expire) begin
                    w_next = ST_ABORT;
                end
            end
            ST_ADDR_RDY: w_next = ST_CMD_WAIT;
            ST_CMD_WAIT: begin
                if (pid_rdy) begin
                    if (rx_pid == PID_OUT) begin
                        w_next = ST_DATA_WAIT;
                    end else if (rx_pid == PID_IN) begin
                        w_next = ST_READ;
                    end else begin
                        w_next    = ST_HS;
                        w_hs_kind = HS_FAIL;
                    end
                end else if (w_to_expire) begin
                    w_next = ST_ABORT;
                end
            end
            ST_DATA_WAIT: begin
                if (rx_packet_done == PKT_GOOD) begin
                    w_next  = ST_WRITE;
                    w_retry = '0;
                end else if (pkt_is_bad(rx_packet_done)) begin
                    w_next    = ST_HS;
                    w_retry   = w_retry_inc;
                    w_hs_kind = (w_retry_inc >= c_RETRY_MAX) ? HS_FAIL : HS_NAK;
                end else if (w_to_expire) begin
                    w_next = ST_ABORT;
                end
            end
            ST_WRITE, ST_READ: begin
                if (sd_done) begin
                    w_next    = ST_HS;
                    w_hs_kind = sd_err ? HS_FAIL : HS_GOOD;
                end else if (w_to_expire) begin
                    w_next = ST_ABORT;
                end
            end
            ST_HS: begin
                if (tx_done) begin
                    if (tx_err) begin
                        w_next = ST_ABORT;
                    end else begin
                        case (r_hs_kind)
                            HS_GOOD: begin
                                w_blocks = r_blocks - BLK_CNT_W'(1);
                                w_next   = (r_blocks == BLK_CNT_W'(1)) ? ST_IDLE : ST_CMD_WAIT;
                            end
                            HS_NAK:  w_next = ST_DATA_WAIT;
                            default: w_next = ST_ABORT;
                        endcase
                    end
                end else if (w_to_expire) begin
                    w_next = ST_ABORT;
                end
            end
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_next == ST_ABORT) begin
            w_xfer_err = 1'b1;
            w_blocks   = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state        <= ST_IDLE;
            r_hs_kind      <= HS_GOOD;
            r_retry        <= '0;
            r_blocks       <= '0;
            r_xfer_err     <= 1'b0;
            r_sd_addr_rdy  <= 1'b0;
            r_sd_write     <= 1'b0;
            r_sd_read      <= 1'b0;
            r_tx_transmit  <= 1'b0;
            r_tx_send_good <= 1'b0;
            r_tx_send_bad  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_hs_kind      <= w_hs_kind;
            r_retry        <= w_retry;
            r_blocks       <= w_blocks;
            r_xfer_err     <= w_xfer_err;
            r_sd_addr_rdy  <= (w_next == ST_ADDR_RDY);
            r_sd_write     <= (w_next == ST_WRITE);
            r_sd_read      <= (w_next == ST_READ);
            r_tx_transmit  <= (w_next == ST_HS);
            r_tx_send_good <= (w_next == ST_HS) && (w_hs_kind == HS_GOOD);
            r_tx_send_bad  <= (w_next == ST_HS) && (w_hs_kind != HS_GOOD);
            r_busy         <= (w_next != ST_IDLE);
        end
    end

    assign sd_addr_rdy  = r_sd_addr_rdy;
    assign sd_write     = r_sd_write;
    assign sd_read      = r_sd_read;
    assign tx_transmit  = r_tx_transmit;
    assign tx_send_good = r_tx_send_good;
    assign tx_send_bad  = r_tx_send_bad;
    assign busy         = r_busy;
    assign xfer_err     = r_xfer_err;
    assign blocks_left  = r_blocks;

endmodule

`default_nettype wire

// File: tb/tb_usb_sd_xfer_ctrl.sv
// ============================================================================
// Module      : tb_usb_sd_xfer_ctrl
// Description : Directed self-checking bench for usb_sd_xfer_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_sd_xfer_ctrl;

    localparam logic [3:0] c_OUT = 4'b0001;
    localparam logic [3:0] c_IN  = 4'b1001;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       pid_rdy;
    logic [3:0] rx_pid;
    logic [1:0] rx_packet_done;
    logic [7:0] setup_blk_cnt;
    logic       sd_done, sd_err, tx_done, tx_err;
    logic       sd_addr_rdy, sd_write, sd_read;
    logic       tx_transmit, tx_send_good, tx_send_bad, busy, xfer_err;
    logic [7:0] blocks_left;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr, n_rd, n_tx;

    usb_sd_xfer_ctrl #(
        .BLK_CNT_W      (8),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRY      (3)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .pid_rdy        (pid_rdy),
        .rx_pid         (rx_pid),
        .rx_packet_done (rx_packet_done),
        .setup_blk_cnt  (setup_blk_cnt),
        .sd_done        (sd_done),
        .sd_err         (sd_err),
        .tx_done        (tx_done),
        .tx_err         (tx_err),
        .sd_addr_rdy    (sd_addr_rdy),
        .sd_write       (sd_write),
        .sd_read        (sd_read),
        .tx_transmit    (tx_transmit),
        .tx_send_good   (tx_send_good),
        .tx_send_bad    (tx_send_bad),
        .busy           (busy),
        .xfer_err       (xfer_err),
        .blocks_left    (blocks_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; also tally strobe activity.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sd_write)    n_wr++;
        if (sd_read)     n_rd++;
        if (tx_transmit) n_tx++;
    endtask

    task automatic pid(input logic [3:0] p);
        pid_rdy = 1'b1; rx_pid = p;
        tick();
        pid_rdy = 1'b0; rx_pid = 4'h0;
    endtask

    task automatic pkt(input logic [1:0] c);
        rx_packet_done = c;
        tick();
        rx_packet_done = 2'b00;
    endtask

    task automatic sd_pulse(input logic e);
        sd_done = 1'b1; sd_err = e;
        tick();
        sd_done = 1'b0; sd_err = 1'b0;
    endtask

    task automatic tx_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Address phase: OUT token, good address packet, then the sd_addr_rdy cycle.
    task automatic addr_phase(input logic [7:0] cnt);
        setup_blk_cnt = cnt;
        pid(c_OUT);
        pkt(2'b01);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; pid_rdy = 1'b0; rx_pid = 4'h0; rx_packet_done = 2'b00;
        setup_blk_cnt = 8'd0; sd_done = 1'b0; sd_err = 1'b0;
        tx_done = 1'b0; tx_err = 1'b0;
        n_wr = 0; n_rd = 0; n_tx = 0;
        tick(); tick();
        check("reset_outputs",
              {23'd0, sd_addr_rdy, sd_write, sd_read, tx_transmit, tx_send_good,
               tx_send_bad, busy, xfer_err, 1'b0} | {24'd0, blocks_left}, 32'd0);
        n_rst = 1'b1;
        tick();

        // Single-block write
        setup_blk_cnt = 8'd1;
        pid(c_OUT);
        check("wr_busy", busy, 1);
        pkt(2'b01);
        check("wr_addr_rdy", sd_addr_rdy, 1);
        check("wr_blocks_latched", blocks_left, 1);
        tick();
        check("wr_addr_rdy_1cyc", sd_addr_rdy, 0);
        pid(c_OUT);
        pkt(2'b01);
        check("wr_strobe", sd_write, 1);
        tick(); tick();
        check("wr_strobe_held", sd_write, 1);
        sd_pulse(1'b0);
        check("wr_hs", {sd_write, tx_transmit, tx_send_good, tx_send_bad}, 4'b0110);
        tick();
        check("wr_hs_held", {tx_transmit, tx_send_good}, 2'b11);
        tx_pulse();
        check("wr_done", {busy, tx_transmit, xfer_err, blocks_left}, {3'b000, 8'd0});

        // Three-block read
        addr_phase(8'd3);
        check("rd_blocks_init", blocks_left, 3);
        n_rd = 0;
        for (int i = 0; i < 3; i++) begin
            pid(c_IN);
            check("rd_strobe", {sd_read, sd_write}, 2'b10);
            sd_pulse(1'b0);
            check("rd_hs_good", {sd_read, tx_transmit, tx_send_good}, 3'b011);
            tx_pulse();
            check("rd_blocks_left", blocks_left, 32'(2 - i));
            check("rd_busy", busy, (i < 2) ? 1 : 0);
        end
        check("rd_strobe_count", n_rd, 3);

        // Two NAKs, then a good data packet completes the write
        addr_phase(8'd1);
        pid(c_OUT);
        for (int i = 0; i < 2; i++) begin
            pkt(2'b10);
            check("retry_nak", {tx_transmit, tx_send_good, tx_send_bad}, 3'b101);
            tx_pulse();
            check("retry_back", {tx_transmit, busy}, 2'b01);
        end
        pkt(2'b01);
        check("retry_write", sd_write, 1);
        sd_pulse(1'b0);
        tx_pulse();
        check("retry_ok", {busy, xfer_err}, 2'b00);

        // Three bad packets exhaust the retries
        addr_phase(8'd1);
        pid(c_OUT);
        n_wr = 0;
        pkt(2'b10); tx_pulse();
        pkt(2'b11); tx_pulse();
        pkt(2'b10);
        check("retry3_nak", {tx_transmit, tx_send_bad}, 2'b11);
        tx_pulse();
        check("retry3_abort", {xfer_err, blocks_left}, {1'b1, 8'd0});
        tick();
        check("retry3_idle", busy, 0);
        check("retry3_no_write", n_wr, 0);

        // Stall in CMD_WAIT until the 16-cycle timeout
        addr_phase(8'd2);
        n_tx = 0;
        repeat (15) tick();
        check("to_before", {busy, xfer_err}, 2'b10);
        tick();
        check("to_abort", {xfer_err, blocks_left}, {1'b1, 8'd0});
        tick();
        check("to_idle", busy, 0);
        check("to_no_hs", n_tx, 0);

        // SD error during write
        addr_phase(8'd1);
        check("sderr_clears_flag", xfer_err, 0);
        pid(c_OUT);
        pkt(2'b01);
        sd_pulse(1'b1);
        check("sderr_hs_bad", {tx_transmit, tx_send_good, tx_send_bad}, 3'b101);
        tx_pulse();
        check("sderr_abort", xfer_err, 1);
        tick();
        check("sderr_sticky", {busy, xfer_err}, 2'b01);
        pid(c_OUT);
        check("sderr_out_clears", {busy, xfer_err}, 2'b10);

        // Bad address packet returns to IDLE without aborting
        pkt(2'b11);
        check("addr_bad_idle", {busy, xfer_err, sd_addr_rdy}, 3'b000);

        // Unsupported PID in IDLE is ignored
        pid(4'b0101);
        check("idle_bad_pid", busy, 0);

        // Zero block count counts as one; reset mid-READ
        addr_phase(8'd0);
        check("zero_cnt_is_one", blocks_left, 1);
        pid(c_IN);
        check("rst_pre_read", sd_read, 1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("rst_mid_read",
              {sd_addr_rdy, sd_write, sd_read, tx_transmit, tx_send_good,
               tx_send_bad, busy, xfer_err, blocks_left}, 32'd0);
        tick();
        check("rst_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
